// File: rtl/gpio_bus_master.sv
// Bus initiator for the GPIO register bus: turns single host commands (read, write,
// set/clear/toggle read-modify-write) into zero-wait bus cycles and returns one response each.
module gpio_bus_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_we,
  output logic              bus_re,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TGL   = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] ADDR_DIR  = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] ADDR_PINS = ADDR_W'(4'h8);
  localparam logic [3:0]        WAIT_LAST = 4'(RD_WAIT);

  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] mask_q;
  logic [3:0]        wait_cnt;
  logic              cmd_bad;
  logic [DATA_W-1:0] rmw_value;

  // Rejected commands never touch the bus: bad opcode, unmapped address, or a store to pin readback.
  always_comb begin
    cmd_bad = 1'b0;
    if (cmd_op > OP_TGL)
      cmd_bad = 1'b1;
    else if (cmd_addr != ADDR_DATA && cmd_addr != ADDR_DIR && cmd_addr != ADDR_PINS)
      cmd_bad = 1'b1;
    else if (cmd_op != OP_READ && cmd_addr == ADDR_PINS)
      cmd_bad = 1'b1;
  end

  // NOTE: the default assignment ahead of the case keeps this always_comb free of latches.
  always_comb begin
    rmw_value = bus_rdata ^ mask_q;
    case (op_q)
      OP_SET:  rmw_value = bus_rdata | mask_q;
      OP_CLR:  rmw_value = bus_rdata & ~mask_q;
      default: rmw_value = bus_rdata ^ mask_q;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      op_q      <= OP_READ;
      mask_q    <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            mask_q    <= cmd_data;
            wait_cnt  <= '0;
            if (cmd_bad) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              bus_addr <= cmd_addr;
              if (cmd_op == OP_WRITE) begin
                state     <= WR;
                bus_we    <= 1'b1;
                bus_wdata <= cmd_data;
              end else begin
                state  <= RD;
                bus_re <= 1'b1;
              end
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD: begin
          // Read data is captured on the edge that closes the last strobe cycle.
          if (wait_cnt == WAIT_LAST) begin
            bus_re <= 1'b0;
            if (op_q == OP_READ) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= bus_rdata;
            end else begin
              state     <= WR;
              bus_we    <= 1'b1;
              bus_wdata <= rmw_value;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WR: begin
          bus_we    <= 1'b0;
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= bus_wdata;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Self-checking bench: two masters (RD_WAIT 0 and 3) each drive a small GPIO responder;
// results are compared against a register-level model of command semantics.
module tb_gpio_bus_master;

  localparam int          DW      = 32;
  localparam int          AW      = 4;
  localparam logic [31:0] PIN_XOR = 32'h0F0F_5A00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid [2];
  logic          cmd_ready [2];
  logic [2:0]    cmd_op    [2];
  logic [AW-1:0] cmd_addr  [2];
  logic [DW-1:0] cmd_data  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_err   [2];
  logic          bus_we    [2];
  logic          bus_re    [2];
  logic [AW-1:0] bus_addr  [2];
  logic [DW-1:0] bus_wdata [2];
  logic [DW-1:0] bus_rdata [2];

  logic [DW-1:0] gpio_data  [2] = '{32'h0, 32'h0};
  logic [DW-1:0] gpio_dir   [2] = '{32'h0, 32'h0};
  int            re_cnt     [2] = '{0, 0};
  int            we_cnt     [2] = '{0, 0};
  logic [AW-1:0] last_waddr [2] = '{4'h0, 4'h0};
  logic [DW-1:0] last_wdata [2] = '{32'h0, 32'h0};
  logic          overlap    [2] = '{1'b0, 1'b0};

  // Register-level model of the GPIO block contents seen by each master.
  logic [DW-1:0] m_data [2] = '{32'h0, 32'h0};
  logic [DW-1:0] m_dir  [2] = '{32'h0, 32'h0};

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gpio_bus_master #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(g == 0 ? 0 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]),
      .cmd_addr(cmd_addr[g]), .cmd_data(cmd_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .rsp_err(rsp_err[g]),
      .bus_we(bus_we[g]), .bus_re(bus_re[g]), .bus_addr(bus_addr[g]),
      .bus_wdata(bus_wdata[g]), .bus_rdata(bus_rdata[g])
    );

    // Zero-wait responder: combinational read data, writes commit on the clock edge.
    assign bus_rdata[g] = !bus_re[g]              ? 32'h0 :
                          (bus_addr[g] == 4'h0)   ? gpio_data[g] :
                          (bus_addr[g] == 4'h4)   ? gpio_dir[g] :
                          (bus_addr[g] == 4'h8)   ? (gpio_data[g] ^ PIN_XOR) : 32'h0;

    always @(posedge clk) begin
      if (bus_re[g]) re_cnt[g] <= re_cnt[g] + 1;
      if (bus_re[g] && bus_we[g]) overlap[g] <= 1'b1;
      if (bus_we[g]) begin
        we_cnt[g]     <= we_cnt[g] + 1;
        last_waddr[g] <= bus_addr[g];
        last_wdata[g] <= bus_wdata[g];
        if (bus_addr[g] == 4'h0) gpio_data[g] <= bus_wdata[g];
        if (bus_addr[g] == 4'h4) gpio_dir[g]  <= bus_wdata[g];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, derived from the command semantics alone.
  task automatic model(input int u, input logic [2:0] op, input logic [3:0] addr,
                       input logic [31:0] d, output logic err, output logic [31:0] rsp,
                       output int lat, output int nre, output int nwe);
    int          w;
    logic [31:0] cur, nv;
    w   = (u == 0) ? 0 : 3;
    err = 1'b0; rsp = 32'h0; lat = 1; nre = 0; nwe = 0;
    if (op > 3'd4 || !(addr == 4'h0 || addr == 4'h4 || addr == 4'h8) ||
        (op != 3'd0 && addr == 4'h8)) begin
      err = 1'b1;
      return;
    end
    cur = (addr == 4'h0) ? m_data[u] : (addr == 4'h4) ? m_dir[u] : (m_data[u] ^ PIN_XOR);
    case (op)
      3'd0: begin rsp = cur; lat = 2 + w; nre = 1 + w; return; end
      3'd1: begin nv = d;          lat = 2;     nre = 0;     end
      3'd2: begin nv = cur | d;    lat = 3 + w; nre = 1 + w; end
      3'd3: begin nv = cur & ~d;   lat = 3 + w; nre = 1 + w; end
      default: begin nv = cur ^ d; lat = 3 + w; nre = 1 + w; end
    endcase
    nwe = 1;
    rsp = nv;
    if (addr == 4'h0) m_data[u] = nv;
    else              m_dir[u]  = nv;
  endtask

  task automatic do_cmd(input int u, input logic [2:0] op, input logic [3:0] addr,
                        input logic [31:0] d, input int stall);
    logic        e_err, stable;
    logic [31:0] e_rsp, held;
    int          e_lat, e_re, e_we, re0, we0, lat, n;
    model(u, op, addr, d, e_err, e_rsp, e_lat, e_re, e_we);
    n = 0;
    @(negedge clk);
    while (!cmd_ready[u] && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_idle", 64'(cmd_ready[u]), 64'd1);
    cmd_valid[u] = 1'b1; cmd_op[u] = op; cmd_addr[u] = addr; cmd_data[u] = d;
    re0 = re_cnt[u]; we0 = we_cnt[u];
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0; cmd_op[u] = 3'($urandom); cmd_data[u] = $urandom;
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", 64'(lat), 64'(e_lat));
    check("rsp_data", 64'(rsp_data[u]), 64'(e_rsp));
    check("rsp_err", 64'(rsp_err[u]), 64'(e_err));
    check("re_cycles", 64'(re_cnt[u] - re0), 64'(e_re));
    check("we_cycles", 64'(we_cnt[u] - we0), 64'(e_we));
    if (e_we != 0) begin
      check("waddr", 64'(last_waddr[u]), 64'(addr));
      check("wdata", 64'(last_wdata[u]), 64'(e_rsp));
    end
    held = rsp_data[u]; stable = 1'b1; re0 = re_cnt[u]; we0 = we_cnt[u];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      stable &= rsp_valid[u] && (rsp_data[u] == held) && (rsp_err[u] == e_err) &&
                !cmd_ready[u] && !bus_re[u] && !bus_we[u];
    end
    if (stall > 0) begin
      check("stall_stable", 64'(stable), 64'd1);
      check("stall_bus_quiet", 64'((re_cnt[u] - re0) + (we_cnt[u] - we0)), 64'd0);
    end
    @(negedge clk); rsp_ready[u] = 1'b1;
    @(posedge clk); #1; rsp_ready[u] = 1'b0;
    check("rsp_dropped", 64'(rsp_valid[u]), 64'd0);
    check("cmd_ready_after", 64'(cmd_ready[u]), 64'd1);
  endtask

  task automatic check_reset_values(input int u);
    check("rst_cmd_ready", 64'(cmd_ready[u]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid[u]), 64'd0);
    check("rst_rsp_data", 64'(rsp_data[u]), 64'd0);
    check("rst_rsp_err", 64'(rsp_err[u]), 64'd0);
    check("rst_strobes", 64'({bus_we[u], bus_re[u]}), 64'd0);
    check("rst_bus_addr", 64'(bus_addr[u]), 64'd0);
    check("rst_bus_wdata", 64'(bus_wdata[u]), 64'd0);
  endtask

  initial begin
    int          we0;
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [3:0]  addr_tbl [5];
    addr_tbl = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_op[u] = 3'd0; cmd_addr[u] = '0; cmd_data[u] = '0;
      rsp_ready[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) check_reset_values(u);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(cmd_ready[0]), 64'd1);

    // Directed sequence.
    do_cmd(0, 3'd1, 4'h0, 32'hA5A5_0001, 0);
    do_cmd(0, 3'd1, 4'h4, 32'h0000_00FF, 0);
    do_cmd(0, 3'd0, 4'h4, 32'h0, 0);
    do_cmd(1, 3'd1, 4'h4, 32'h0000_00FF, 0);
    do_cmd(1, 3'd0, 4'h4, 32'h0, 0);
    do_cmd(0, 3'd1, 4'h0, 32'h1234_0005, 0);
    do_cmd(0, 3'd2, 4'h0, 32'h0000_0F00, 0);
    do_cmd(0, 3'd1, 4'h0, 32'h1234_0005, 0);
    do_cmd(0, 3'd3, 4'h0, 32'h0000_0005, 0);
    do_cmd(0, 3'd4, 4'h0, 32'hFFFF_FFFF, 0);
    do_cmd(1, 3'd4, 4'h0, 32'h8000_0001, 1);
    do_cmd(0, 3'd6, 4'h0, 32'h1111_1111, 0);
    do_cmd(0, 3'd1, 4'h8, 32'h2222_2222, 0);
    do_cmd(0, 3'd0, 4'hC, 32'h0, 0);
    do_cmd(0, 3'd0, 4'h8, 32'h0, 0);
    do_cmd(0, 3'd0, 4'h4, 32'h0, 10);

    // Reset while a SET is in its read phase: no write, no response.
    @(negedge clk);
    we0 = we_cnt[0];
    cmd_valid[0] = 1'b1; cmd_op[0] = 3'd2; cmd_addr[0] = 4'h0; cmd_data[0] = 32'h00FF_0000;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    check("rmw_in_rd", 64'(bus_re[0]), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values(0);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_write_after_reset", 64'(we_cnt[0] - we0), 64'd0);
    check("no_rsp_after_reset", 64'(rsp_valid[0]), 64'd0);
    check("reg_untouched", 64'(gpio_data[0]), 64'(m_data[0]));
    do_cmd(0, 3'd1, 4'h0, 32'hC0DE_0042, 0);
    do_cmd(0, 3'd0, 4'h0, 32'h0, 0);

    // Randomized traffic on both masters.
    for (int k = 0; k < 30; k++) begin
      for (int u = 0; u < 2; u++) begin
        op   = ($urandom_range(0, 9) == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        addr = addr_tbl[$urandom_range(0, 4)];
        if ($urandom_range(0, 7) == 0) addr = 4'($urandom);
        do_cmd(u, op, addr, $urandom, int'($urandom_range(0, 3)));
      end
    end

    check("no_overlap0", 64'(overlap[0]), 64'd0);
    check("no_overlap1", 64'(overlap[1]), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_bus_master.md
Name: gpio_bus_master

Overview:
Bus initiator for the GPIO register bus (we/re/addr/wdata/rdata, zero-wait responder: writes commit on the clock edge, read data is combinational while re is high). It accepts single commands from a host-side valid/ready channel and turns them into bus cycles. It supports read, write and atomic set/clear/toggle read-modify-write, and returns one response per command on a valid/ready channel. It sits between the CPU/sequencer and the GPIO register block.

Parameters:
DATA_W, 32, bus and command data width
ADDR_W, 4, bus address width
RD_WAIT, 0, extra cycles bus_re is held before rdata is sampled (0..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&ready
cmd_op  input  3  0 READ, 1 WRITE, 2 SET, 3 CLR, 4 TGL, 5-7 illegal
cmd_addr  input  ADDR_W  target register: 0x0 data, 0x4 dir, 0x8 pin readback (read-only)
cmd_data  input  DATA_W  write value or bit mask
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&ready
rsp_data  output  DATA_W  result value
rsp_err  output  1  command rejected, no bus cycle issued
bus_we  output  1  write strobe to GPIO
bus_re  output  1  read strobe to GPIO
bus_addr  output  ADDR_W  bus address
bus_wdata  output  DATA_W  bus write data
bus_rdata  input  DATA_W  bus read data

Behaviour:
- Reset values: cmd_ready=0 on the reset cycle, then 1 in IDLE. rsp_valid=0, rsp_data=0, rsp_err=0, bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0. FSM=IDLE, wait counter=0.
- FSM states: IDLE, RD, WR, RSP.
- cmd_ready=1 only in IDLE. One command is outstanding at a time.
- On acceptance, latch op, addr and data into holding registers. Then branch:
  - Illegal op, addr not in {0x0,0x4,0x8}, or WRITE/SET/CLR/TGL to 0x8: go to RSP with rsp_err=1 and rsp_data=0. No bus strobe is issued.
  - READ, SET, CLR, TGL: go to RD.
  - WRITE: go to WR.
- RD: bus_re=1 and bus_addr=latched addr for RD_WAIT+1 cycles. bus_rdata is sampled at the clock edge ending the last RD cycle.
  - READ: go to RSP with rsp_data=sampled value.
  - SET/CLR/TGL: compute new = rd|mask, rd&~mask, or rd^mask. Go to WR with bus_wdata=new.
- WR: bus_we=1 for exactly one cycle, with bus_addr and bus_wdata held. Then go to RSP.
  - rsp_data = cmd_data for WRITE; rsp_data = new value for RMW.
- RSP: rsp_valid=1. rsp_data/rsp_err are held stable until rsp_ready. On valid&ready, go to IDLE; cmd_ready rises the next cycle.
- bus_re and bus_we are never high together. Both are 0 outside RD/WR.
- All bus_* outputs come from registers. There is no combinational path from cmd_* or rsp_ready to bus_*.
- Latency from the acceptance edge to rsp_valid high, with RD_WAIT=0:
  - error: 1 cycle
  - WRITE: 2 cycles
  - READ: 2 cycles
  - RMW: 3 cycles
  - RD_WAIT adds its value to READ and RMW.
- RMW atomicity: no other command is accepted between its RD and WR cycles.
- Back-to-back: the earliest next acceptance is the cycle after the rsp handshake. No command is lost, because cmd_ready=0 while busy.
- rsp_ready held high in IDLE has no effect. rsp_ready low stalls RSP indefinitely, with outputs frozen.
- Reset mid-operation: FSM returns to IDLE and strobes drop at the reset edge. If an RMW is in RD, no write is issued and no response is produced.
- Widths: all data operations are DATA_W bits, with no truncation. bus_addr is passed through unmodified.

Test Plan:
- WRITE 0x0 data 0xA5A5_0001 -> bus_we high exactly 1 cycle with addr 0x0, wdata 0xA5A5_0001; rsp_valid 2 cycles after accept, rsp_data 0xA5A5_0001, rsp_err 0.
- READ 0x4 with responder returning 0x0000_00FF -> bus_re 1 cycle, bus_we never high; rsp_data 0x0000_00FF at latency 2. Repeat with RD_WAIT=3 -> bus_re held 4 cycles, latency 5.
- SET 0x0 mask 0x0000_0F00 with register 0x1234_0005 -> read then write 0x1234_0F05. CLR mask 0x0000_0005 -> 0x1234_0000. TGL mask 0xFFFF_FFFF on 0x0 -> 0xEDCB_FFFF. Each rsp_data equals the written value.
- Errors: op=6; WRITE to 0x8; READ 0xC -> rsp_err=1, rsp_data=0, latency 1, zero bus strobes.
- Backpressure: hold rsp_ready=0 for 10 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0, no bus activity; release -> cmd_ready=1 the next cycle.
- Reset asserted during RD of a SET -> no bus_we ever pulses, rsp_valid=0, all outputs at reset values; next WRITE completes normally.
